coeff_loader: RTL and testbench



---
 rtl/coeff_loader.sv | 180 ++++++++++++++++++
 tb/tb_coeff_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_loader.sv
// Bit-serial coefficient loader: assembles 53 words into a shadow bank and
// commits the whole bank to the comparator-facing registers in one cycle.
module coeff_loader #(
    parameter int WORD_W    = 32,
    parameter int LIMIT_W   = 20,
    parameter int NUM_WORDS = 53
) (
    input  logic               clk,
    input  logic               GlobalReset,
    input  logic               load_start,
    input  logic               scan_in,
    input  logic               scan_valid,
    output logic               busy,
    output logic               load_done,
    output logic [LIMIT_W-1:0] section_limit,
    output logic [WORD_W-1:0]  coeff1_0, coeff1_1, coeff1_2, coeff1_3, coeff1_4, coeff1_5,
    output logic [WORD_W-1:0]  coeff1_6, coeff1_7, coeff1_8, coeff1_9, coeff1_10,
    output logic [WORD_W-1:0]  coeff2_0, coeff2_1, coeff2_2, coeff2_3, coeff2_4, coeff2_5,
    output logic [WORD_W-1:0]  coeff2_6, coeff2_7, coeff2_8, coeff2_9, coeff2_10,
    output logic [WORD_W-1:0]  coeff3_0, coeff3_1, coeff3_2, coeff3_3, coeff3_4, coeff3_5,
    output logic [WORD_W-1:0]  coeff3_6, coeff3_7, coeff3_8, coeff3_9, coeff3_10,
    output logic [WORD_W-1:0]  coeff4_0, coeff4_1, coeff4_2, coeff4_3, coeff4_4, coeff4_5,
    output logic [WORD_W-1:0]  coeff4_6, coeff4_7, coeff4_8, coeff4_9, coeff4_10,
    output logic [WORD_W-1:0]  mean1, mean2, mean3, mean4,
    output logic [WORD_W-1:0]  std1, std2, std3, std4
);

    localparam int BIT_W = $clog2(WORD_W);
    localparam int CNT_W = $clog2(NUM_WORDS);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t              state;
    logic [BIT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    word_cnt;
    logic [WORD_W-2:0]   shift_reg;
    logic [WORD_W-1:0]   word_in;
    logic [LIMIT_W-1:0]  shadow_limit;
    logic [WORD_W-1:0]   shadow [1:NUM_WORDS-1];
    logic [WORD_W-1:0]   active [1:NUM_WORDS-1];

    assign word_in = {shift_reg, scan_in};

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            load_done     <= 1'b0;
            bit_cnt       <= '0;
            word_cnt      <= '0;
            shift_reg     <= '0;
            shadow_limit  <= '0;
            section_limit <= '0;
            for (int i = 1; i < NUM_WORDS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // A restart wins over any scan bit presented in the same cycle.
                    if (load_start) begin
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end else if (scan_valid) begin
                        shift_reg <= word_in[WORD_W-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (word_cnt == '0) begin
                                shadow_limit <= word_in[LIMIT_W-1:0];
                            end else begin
                                shadow[word_cnt] <= word_in;
                            end
                            if (word_cnt == LAST_WORD) begin
                                word_cnt  <= '0;
                                state     <= COMMIT;
                                load_done <= 1'b1;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    section_limit <= shadow_limit;
                    for (int i = 1; i < NUM_WORDS; i++) begin
                        active[i] <= shadow[i];
                    end
                    if (load_start) begin
                        state    <= SHIFT;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Each section occupies 13 consecutive words: 11 coefficients, mean, std.
    assign coeff1_0  = active[1];
    assign coeff1_1  = active[2];
    assign coeff1_2  = active[3];
    assign coeff1_3  = active[4];
    assign coeff1_4  = active[5];
    assign coeff1_5  = active[6];
    assign coeff1_6  = active[7];
    assign coeff1_7  = active[8];
    assign coeff1_8  = active[9];
    assign coeff1_9  = active[10];
    assign coeff1_10 = active[11];
    assign mean1     = active[12];
    assign std1      = active[13];

    assign coeff2_0  = active[14];
    assign coeff2_1  = active[15];
    assign coeff2_2  = active[16];
    assign coeff2_3  = active[17];
    assign coeff2_4  = active[18];
    assign coeff2_5  = active[19];
    assign coeff2_6  = active[20];
    assign coeff2_7  = active[21];
    assign coeff2_8  = active[22];
    assign coeff2_9  = active[23];
    assign coeff2_10 = active[24];
    assign mean2     = active[25];
    assign std2      = active[26];

    assign coeff3_0  = active[27];
    assign coeff3_1  = active[28];
    assign coeff3_2  = active[29];
    assign coeff3_3  = active[30];
    assign coeff3_4  = active[31];
    assign coeff3_5  = active[32];
    assign coeff3_6  = active[33];
    assign coeff3_7  = active[34];
    assign coeff3_8  = active[35];
    assign coeff3_9  = active[36];
    assign coeff3_10 = active[37];
    assign mean3     = active[38];
    assign std3      = active[39];

    assign coeff4_0  = active[40];
    assign coeff4_1  = active[41];
    assign coeff4_2  = active[42];
    assign coeff4_3  = active[43];
    assign coeff4_4  = active[44];
    assign coeff4_5  = active[45];
    assign coeff4_6  = active[46];
    assign coeff4_7  = active[47];
    assign coeff4_8  = active[48];
    assign coeff4_9  = active[49];
    assign coeff4_10 = active[50];
    assign mean4     = active[51];
    assign std4      = active[52];

endmodule

// File: tb/tb_coeff_loader.sv
// Directed bench for coeff_loader: full loads, gapped streams, abort/restart,
// mid-load reset, idle scan noise and section_limit truncation.
module tb_coeff_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        GlobalReset, load_start, scan_in, scan_valid;
    logic        busy, load_done;
    logic [19:0] section_limit;
    logic [31:0] obs [1:52];

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cycles = 0;
    int done_pulses = 0;
    int gap_cnt;
    int b0, d0;

    logic [31:0] words [53];
    logic [31:0] exp_act [1:52];
    logic [19:0] exp_lim;

    coeff_loader dut (
        .clk(clk), .GlobalReset(GlobalReset), .load_start(load_start),
        .scan_in(scan_in), .scan_valid(scan_valid), .busy(busy), .load_done(load_done),
        .section_limit(section_limit),
        .coeff1_0(obs[1]),  .coeff1_1(obs[2]),  .coeff1_2(obs[3]),  .coeff1_3(obs[4]),
        .coeff1_4(obs[5]),  .coeff1_5(obs[6]),  .coeff1_6(obs[7]),  .coeff1_7(obs[8]),
        .coeff1_8(obs[9]),  .coeff1_9(obs[10]), .coeff1_10(obs[11]),
        .mean1(obs[12]), .std1(obs[13]),
        .coeff2_0(obs[14]), .coeff2_1(obs[15]), .coeff2_2(obs[16]), .coeff2_3(obs[17]),
        .coeff2_4(obs[18]), .coeff2_5(obs[19]), .coeff2_6(obs[20]), .coeff2_7(obs[21]),
        .coeff2_8(obs[22]), .coeff2_9(obs[23]), .coeff2_10(obs[24]),
        .mean2(obs[25]), .std2(obs[26]),
        .coeff3_0(obs[27]), .coeff3_1(obs[28]), .coeff3_2(obs[29]), .coeff3_3(obs[30]),
        .coeff3_4(obs[31]), .coeff3_5(obs[32]), .coeff3_6(obs[33]), .coeff3_7(obs[34]),
        .coeff3_8(obs[35]), .coeff3_9(obs[36]), .coeff3_10(obs[37]),
        .mean3(obs[38]), .std3(obs[39]),
        .coeff4_0(obs[40]), .coeff4_1(obs[41]), .coeff4_2(obs[42]), .coeff4_3(obs[43]),
        .coeff4_4(obs[44]), .coeff4_5(obs[45]), .coeff4_6(obs[46]), .coeff4_7(obs[47]),
        .coeff4_8(obs[48]), .coeff4_9(obs[49]), .coeff4_10(obs[50]),
        .mean4(obs[51]), .std4(obs[52])
    );

    always @(posedge clk) begin
        if (busy) busy_cycles++;
        if (load_done) done_pulses++;
    end

    function automatic logic [31:0] b2w(input logic b);
        return {31'b0, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int k = 0; k < 53; k++) words[k] = base + 32'(k);
    endtask

    task automatic send_bits(input int nbits, input bit gapped);
        int g;
        for (int b = 0; b < nbits; b++) begin
            scan_valid = 1'b1;
            scan_in    = words[b / 32][31 - (b % 32)];
            step();
            if (gapped && b < nbits - 1) begin
                g = $urandom_range(0, 3);
                scan_valid = 1'b0;
                scan_in    = 1'($urandom_range(0, 1));
                repeat (g) step();
                gap_cnt += g;
            end
        end
        scan_valid = 1'b0;
        scan_in    = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic commit_model();
        for (int i = 1; i < 53; i++) exp_act[i] = words[i];
        exp_lim = words[0][19:0];
    endtask

    task automatic zero_model();
        for (int i = 1; i < 53; i++) exp_act[i] = '0;
        exp_lim = '0;
    endtask

    task automatic check_bank(input string tag);
        check({tag, "_lim"}, {12'h0, section_limit}, {12'h0, exp_lim});
        for (int i = 1; i < 53; i++)
            check($sformatf("%s_w%0d", tag, i), obs[i], exp_act[i]);
    endtask

    initial begin
        GlobalReset = 1'b1;
        load_start  = 1'b0;
        scan_in     = 1'b0;
        scan_valid  = 1'b0;
        zero_model();
        repeat (3) step();
        GlobalReset = 1'b0;
        step();
        check("rst_busy", b2w(busy), 32'd0);
        check("rst_done", b2w(load_done), 32'd0);
        check_bank("rst");

        // Gap-free load after reset, with commit latency checked edge by edge
        fill(32'h1000_0000);
        b0 = busy_cycles; d0 = done_pulses;
        start_load();
        check("t1_busy_start", b2w(busy), 32'd1);
        send_bits(1696, 1'b0);
        check("t1_done_hi", b2w(load_done), 32'd1);
        check("t1_busy_commit", b2w(busy), 32'd1);
        check("t1_hold_pre", obs[1], 32'h0);
        step();
        check("t1_done_lo", b2w(load_done), 32'd0);
        check("t1_busy_lo", b2w(busy), 32'd0);
        check("t1_busy_cycles", 32'(busy_cycles - b0), 32'd1697);
        check("t1_pulses", 32'(done_pulses - d0), 32'd1);
        check("t1_limit", {12'h0, section_limit}, 32'h0);
        check("t1_coeff1_0", obs[1], 32'h1000_0001);
        check("t1_std1", obs[13], 32'h1000_000D);
        check("t1_coeff2_0", obs[14], 32'h1000_000E);
        check("t1_std4", obs[52], 32'h1000_0034);
        commit_model();
        check_bank("t1");

        // Same stream with random gaps after a reset
        GlobalReset = 1'b1; step(); GlobalReset = 1'b0;
        zero_model();
        check("t2_cleared", obs[1], 32'h0);
        gap_cnt = 0;
        b0 = busy_cycles; d0 = done_pulses;
        start_load();
        send_bits(1696, 1'b1);
        check("t2_done_hi", b2w(load_done), 32'd1);
        step();
        check("t2_busy_cycles", 32'(busy_cycles - b0), 32'(1697 + gap_cnt));
        check("t2_pulses", 32'(done_pulses - d0), 32'd1);
        commit_model();
        check_bank("t2");

        // Load B aborted after 700 bits, load C restarts and commits
        fill(32'hB000_0000);
        d0 = done_pulses;
        start_load();
        send_bits(700, 1'b0);
        check("t3_holdA_1", obs[1], 32'h1000_0001);
        check("t3_holdA_52", obs[52], 32'h1000_0034);
        load_start = 1'b1; scan_valid = 1'b1; scan_in = 1'b1;
        step();
        load_start = 1'b0; scan_valid = 1'b0; scan_in = 1'b0;
        check("t3_busy_restart", b2w(busy), 32'd1);
        fill(32'hA000_0000);
        send_bits(1696, 1'b0);
        check("t3_holdA_commit", obs[32], 32'h1000_0020);
        step();
        check("t3_pulses", 32'(done_pulses - d0), 32'd1);
        check("t3_coeff3_5", obs[32], 32'hA000_0020);
        commit_model();
        check_bank("t3");

        // Reset at word 30 of a second load, then a normal load
        fill(32'hD000_0000);
        d0 = done_pulses;
        start_load();
        send_bits(30 * 32, 1'b0);
        GlobalReset = 1'b1; load_start = 1'b1; scan_valid = 1'b1; scan_in = 1'b1;
        step();
        GlobalReset = 1'b0; load_start = 1'b0; scan_valid = 1'b0; scan_in = 1'b0;
        zero_model();
        check("t4_busy", b2w(busy), 32'd0);
        check("t4_done", b2w(load_done), 32'd0);
        check_bank("t4_rst");
        send_bits(23 * 32, 1'b0);
        repeat (3) step();
        check("t4_no_pulse", 32'(done_pulses - d0), 32'd0);
        check("t4_busy_idle", b2w(busy), 32'd0);
        check("t4_still_zero", obs[1], 32'h0);
        fill(32'h2000_0000);
        d0 = done_pulses;
        start_load();
        send_bits(1696, 1'b0);
        step();
        check("t4_pulses", 32'(done_pulses - d0), 32'd1);
        commit_model();
        check_bank("t4_after");

        // Scan noise while idle
        b0 = busy_cycles; d0 = done_pulses;
        for (int i = 0; i < 100; i++) begin
            scan_valid = 1'b1;
            scan_in    = 1'($urandom_range(0, 1));
            step();
        end
        scan_valid = 1'b0;
        check("t5_busy_cycles", 32'(busy_cycles - b0), 32'd0);
        check("t5_pulses", 32'(done_pulses - d0), 32'd0);
        check("t5_word_cnt", {26'h0, dut.word_cnt}, 32'd0);
        check_bank("t5");

        // Upper bits of word 0 are discarded
        fill(32'h3000_0000);
        words[0] = 32'hFFF1_2345;
        start_load();
        send_bits(1696, 1'b0);
        step();
        check("t6_limit", {12'h0, section_limit}, 32'h0001_2345);
        commit_model();
        check_bank("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
